// File: rtl/mem_pkg.sv
// Shared types and widths for the memory stage of the 16-bit pipelined core.
// Optional stall counter is enabled with MEM_STALL_CNT_EN.
package mem_pkg;

  localparam int unsigned DATA_W = 16;
  localparam int unsigned ADDR_W = 8;
  localparam int unsigned REG_W  = 3;
  localparam int unsigned STAT_W = 3;
  localparam int unsigned CNT_W  = 16;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] store;
    logic [REG_W-1:0]  rd;
    logic              reg_wr;
    logic              mem_rd;
    logic              mem_wr;
    logic [STAT_W-1:0] status;
    logic              status_wr;
  } ex_mem_t;

  typedef struct packed {
    logic              valid;
    logic [DATA_W-1:0] data;
    logic [REG_W-1:0]  rd;
    logic              reg_wr;
  } mem_wb_t;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;

endpackage

// File: rtl/mem_handshake_fsm.sv
// Data-memory req/ack handshake: wait-state tracking, stall and request generation.
// MEM_STALL_CNT_EN adds a saturating count of stalled cycles.
module mem_handshake_fsm
  import mem_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             memop,
  input  logic             dmem_ack,
  output logic             stall_c,
  output logic             dmem_req_c
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles
`endif
);

  mem_state_t state_q, state_d;

  // Zero-wait memories ack in the request cycle, so the stall is purely combinational.
  assign stall_c    = memop & ~dmem_ack;
  assign dmem_req_c = memop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (memop && !dmem_ack) state_d = WAIT;
      WAIT:    if (dmem_ack) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef MEM_STALL_CNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (stall_c && (cnt_q != {CNT_W{1'b1}})) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign stall_cycles = cnt_q;
`endif

endmodule

// File: rtl/mem_stage.sv
// Memory stage: EX/MEM and MEM/WB registers, data-memory interface, forwarding sources, status flags.
// Define MEM_STALL_CNT_EN to expose the stall_cycles counter.
module mem_stage
  import mem_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  input  logic [DATA_W-1:0] ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic [REG_W-1:0]  ex_rd,
  input  logic              ex_reg_wr,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [STAT_W-1:0] ex_status,
  input  logic              ex_status_wr,
  output logic              stall,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
  output logic [DATA_W-1:0] mem_data,
  output logic [REG_W-1:0]  mem_rd,
  output logic              mem_reg_wr,
  output logic              mem_is_load,
  output logic [DATA_W-1:0] wb_data,
  output logic [REG_W-1:0]  wb_rd,
  output logic              wb_reg_wr,
  output logic [STAT_W-1:0] status_q
`ifdef MEM_STALL_CNT_EN
  ,
  output logic [CNT_W-1:0]  stall_cycles
`endif
);

  ex_mem_t           m_q, m_d;
  mem_wb_t           w_q, w_d;
  logic [STAT_W-1:0] status_d;
  logic              memop;
  logic              m_load;

  assign memop  = m_q.valid & (m_q.mem_rd | m_q.mem_wr);
  assign m_load = m_q.valid & m_q.mem_rd & ~m_q.mem_wr;

  mem_handshake_fsm u_fsm (
    .clk          (clk),
    .reset        (reset),
    .memop        (memop),
    .dmem_ack     (dmem_ack),
    .stall_c      (stall),
    .dmem_req_c   (dmem_req)
`ifdef MEM_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  // EX/MEM capture; a bubble clears the whole record. Store wins over load.
  always_comb begin
    m_d = m_q;
    if (!stall) begin
      m_d = '0;
      if (ex_valid) begin
        m_d.valid     = 1'b1;
        m_d.alu       = ex_alu_out;
        m_d.store     = ex_store_data;
        m_d.rd        = ex_rd;
        m_d.reg_wr    = ex_reg_wr;
        m_d.mem_rd    = ex_mem_rd & ~ex_mem_wr;
        m_d.mem_wr    = ex_mem_wr;
        m_d.status    = ex_status;
        m_d.status_wr = ex_status_wr;
      end
    end
  end

  // MEM/WB capture; held during a stall so the frozen EX keeps its forwarding value.
  always_comb begin
    w_d = w_q;
    if (!stall) begin
      w_d.valid  = m_q.valid;
      w_d.data   = m_load ? dmem_rdata : m_q.alu;
      w_d.rd     = m_q.rd;
      w_d.reg_wr = m_q.valid & m_q.reg_wr & ~m_q.mem_wr;
    end
  end

  always_comb begin
    status_d = status_q;
    if (!stall && ex_valid && ex_status_wr) status_d = ex_status;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      m_q      <= '0;
      w_q      <= '0;
      status_q <= '0;
    end else begin
      m_q      <= m_d;
      w_q      <= w_d;
      status_q <= status_d;
    end
  end

  assign dmem_we     = m_q.mem_wr;
  assign dmem_addr   = m_q.alu[ADDR_W-1:0];
  assign dmem_wdata  = m_q.store;
  assign mem_data    = m_q.alu;
  assign mem_rd      = m_q.rd;
  assign mem_reg_wr  = m_q.valid & m_q.reg_wr & ~m_q.mem_wr;
  assign mem_is_load = m_load;
  assign wb_data     = w_q.data;
  assign wb_rd       = w_q.rd;
  assign wb_reg_wr   = w_q.reg_wr;

  // Flags are taken at EX capture; the M copies are kept for the record layout only.
  logic unused_fields;
  assign unused_fields = ^{m_q.status, m_q.status_wr, w_q.valid};

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus hand-written wait/reset sequences.
module tb_mem_stage;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        ex_valid;
  logic [15:0] ex_alu_out, ex_store_data;
  logic [2:0]  ex_rd;
  logic        ex_reg_wr, ex_mem_rd, ex_mem_wr;
  logic [2:0]  ex_status;
  logic        ex_status_wr;
  logic        stall, dmem_req, dmem_we;
  logic [7:0]  dmem_addr;
  logic [15:0] dmem_wdata, dmem_rdata;
  logic        dmem_ack;
  logic [15:0] mem_data;
  logic [2:0]  mem_rd;
  logic        mem_reg_wr, mem_is_load;
  logic [15:0] wb_data;
  logic [2:0]  wb_rd;
  logic        wb_reg_wr;
  logic [2:0]  status_q;
`ifdef MEM_STALL_CNT_EN
  logic [15:0] stall_cycles;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_alu_out(ex_alu_out), .ex_store_data(ex_store_data),
    .ex_rd(ex_rd), .ex_reg_wr(ex_reg_wr), .ex_mem_rd(ex_mem_rd), .ex_mem_wr(ex_mem_wr),
    .ex_status(ex_status), .ex_status_wr(ex_status_wr),
    .stall(stall), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .mem_data(mem_data), .mem_rd(mem_rd), .mem_reg_wr(mem_reg_wr), .mem_is_load(mem_is_load),
    .wb_data(wb_data), .wb_rd(wb_rd), .wb_reg_wr(wb_reg_wr), .status_q(status_q)
`ifdef MEM_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  typedef struct {
    logic v; logic [15:0] alu; logic [15:0] sd; logic [2:0] rd; logic rw; logic mr; logic mw;
    logic [2:0] st; logic sw; logic ack; logic [15:0] rdata;
    logic e_stall; logic e_req; logic e_we; logic [7:0] e_addr; logic [15:0] e_wdata;
    logic [15:0] e_mdata; logic [2:0] e_mrd; logic e_mrw; logic e_load;
    logic [15:0] e_wbd; logic [2:0] e_wbrd; logic e_wbw; logic [2:0] e_st;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ex(input logic v, input logic [15:0] alu, input logic [15:0] sd,
                        input logic [2:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic [2:0] st, input logic sw);
    ex_valid = v; ex_alu_out = alu; ex_store_data = sd; ex_rd = rd;
    ex_reg_wr = rw; ex_mem_rd = mr; ex_mem_wr = mw; ex_status = st; ex_status_wr = sw;
  endtask

  // Runs a held memory access; ack arrives after ack_at wait cycles. Returns observed stall count.
  task automatic wait_access(input int ack_at, input logic [15:0] rdata,
                             input logic [15:0] hold_alu, output int waits);
    bit done;
    waits = 0;
    done  = 0;
    for (int c = 0; c < 10 && !done; c++) begin
      dmem_ack   = (c == ack_at);
      dmem_rdata = (c == ack_at) ? rdata : 16'h0000;
      #1;
      if (stall) begin
        waits++;
        chk($sformatf("hold mem_data c%0d", c), mem_data, hold_alu);
        chk($sformatf("req during wait c%0d", c), 16'(dmem_req), 16'h1);
        if (c >= 1) chk($sformatf("state WAIT c%0d", c), 16'(dut.u_fsm.state_q), 16'(WAIT));
      end else begin
        done = 1;
      end
      tick();
    end
    chk("ack seen within bound", 16'(done), 16'h1);
    dmem_ack   = 1'b0;
    dmem_rdata = 16'h0000;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int waits;

    //         v  alu       sd        rd rw mr mw st      sw ack rdata     stl req we addr   wdata     mdata     mrd mrw ld wbd       wbrd wbw st
    vecs[0] = '{1, 16'h0042, 16'h0000, 3, 1, 0, 0, 3'b000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 3'b000};
    vecs[1] = '{1, 16'h0005, 16'h1234, 1, 0, 0, 1, 3'b000, 0, 0, 16'h0000, 0, 0, 0, 8'h42, 16'h0000, 16'h0042, 3, 1, 0, 16'h0000, 0, 0, 3'b000};
    vecs[2] = '{1, 16'h0110, 16'h0000, 5, 1, 1, 0, 3'b000, 0, 1, 16'h0000, 0, 1, 1, 8'h05, 16'h1234, 16'h0005, 1, 0, 0, 16'h0042, 3, 1, 3'b000};
    vecs[3] = '{1, 16'h00A7, 16'h5A5A, 2, 1, 1, 1, 3'b000, 0, 1, 16'hCAFE, 0, 1, 0, 8'h10, 16'h0000, 16'h0110, 5, 1, 1, 16'h0005, 1, 0, 3'b000};
    vecs[4] = '{1, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'b101, 1, 1, 16'h0000, 0, 1, 1, 8'hA7, 16'h5A5A, 16'h00A7, 2, 0, 0, 16'hCAFE, 5, 1, 3'b000};
    vecs[5] = '{0, 16'hFFFF, 16'hFFFF, 7, 1, 1, 0, 3'b010, 1, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, 16'h00A7, 2, 0, 3'b101};
    vecs[6] = '{1, 16'h1234, 16'h0000, 4, 1, 0, 0, 3'b111, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, 16'h0000, 0, 0, 3'b101};
    vecs[7] = '{0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 0, 0, 0, 8'h34, 16'h0000, 16'h1234, 4, 1, 0, 16'h0000, 0, 0, 3'b101};
    vecs[8] = '{0, 16'h0000, 16'h0000, 0, 0, 0, 0, 3'b000, 0, 0, 16'h0000, 0, 0, 0, 8'h00, 16'h0000, 16'h0000, 0, 0, 0, 16'h1234, 4, 1, 3'b101};

    reset = 1'b1;
    set_ex(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 3'b000, 0);
    dmem_ack = 1'b0;
    dmem_rdata = 16'h0000;
    tick();
    tick();
    chk("reset stall", 16'(stall), 16'h0);
    chk("reset dmem_req", 16'(dmem_req), 16'h0);
    chk("reset dmem_we", 16'(dmem_we), 16'h0);
    chk("reset wb_reg_wr", 16'(wb_reg_wr), 16'h0);
    chk("reset status_q", 16'(status_q), 16'h0);
    chk("reset state", 16'(dut.u_fsm.state_q), 16'(IDLE));
    reset = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      set_ex(vecs[i].v, vecs[i].alu, vecs[i].sd, vecs[i].rd, vecs[i].rw, vecs[i].mr,
             vecs[i].mw, vecs[i].st, vecs[i].sw);
      dmem_ack   = vecs[i].ack;
      dmem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("row%0d stall", i), 16'(stall), 16'(vecs[i].e_stall));
      chk($sformatf("row%0d dmem_req", i), 16'(dmem_req), 16'(vecs[i].e_req));
      chk($sformatf("row%0d dmem_we", i), 16'(dmem_we), 16'(vecs[i].e_we));
      chk($sformatf("row%0d dmem_addr", i), 16'(dmem_addr), 16'(vecs[i].e_addr));
      chk($sformatf("row%0d dmem_wdata", i), dmem_wdata, vecs[i].e_wdata);
      chk($sformatf("row%0d mem_data", i), mem_data, vecs[i].e_mdata);
      chk($sformatf("row%0d mem_rd", i), 16'(mem_rd), 16'(vecs[i].e_mrd));
      chk($sformatf("row%0d mem_reg_wr", i), 16'(mem_reg_wr), 16'(vecs[i].e_mrw));
      chk($sformatf("row%0d mem_is_load", i), 16'(mem_is_load), 16'(vecs[i].e_load));
      chk($sformatf("row%0d wb_data", i), wb_data, vecs[i].e_wbd);
      chk($sformatf("row%0d wb_rd", i), 16'(wb_rd), 16'(vecs[i].e_wbrd));
      chk($sformatf("row%0d wb_reg_wr", i), 16'(wb_reg_wr), 16'(vecs[i].e_wbw));
      chk($sformatf("row%0d status_q", i), 16'(status_q), 16'(vecs[i].e_st));
      tick();
    end

    // Load with two wait cycles; EX presents a new op that must stay out of M until ack.
    set_ex(1, 16'h0110, 16'h0000, 3'd6, 1, 1, 0, 3'b000, 0);
    dmem_ack = 1'b0;
    tick();
    set_ex(1, 16'h7777, 16'h0000, 3'd7, 1, 0, 0, 3'b000, 0);
    #1;
    chk("load dmem_addr", 16'(dmem_addr), 16'h0010);
    chk("load dmem_we", 16'(dmem_we), 16'h0);
    chk("load mem_is_load", 16'(mem_is_load), 16'h1);
    chk("load mem_reg_wr", 16'(mem_reg_wr), 16'h1);
    wait_access(2, 16'hBEEF, 16'h0110, waits);
    chk("load stall cycles", 16'(waits), 16'd2);
    chk("load wb_data", wb_data, 16'hBEEF);
    chk("load wb_rd", 16'(wb_rd), 16'd6);
    chk("load wb_reg_wr", 16'(wb_reg_wr), 16'h1);
    chk("post-load mem_data", mem_data, 16'h7777);
    chk("post-load state", 16'(dut.u_fsm.state_q), 16'(IDLE));

    // Reset while waiting on a load.
    set_ex(1, 16'h0001, 16'h0000, 3'd1, 1, 0, 0, 3'b000, 0);
    tick();
    set_ex(1, 16'h0020, 16'h0000, 3'd2, 1, 1, 0, 3'b000, 0);
    tick();
    set_ex(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 3'b000, 0);
    tick();
    chk("pre-reset stall", 16'(stall), 16'h1);
    chk("pre-reset state", 16'(dut.u_fsm.state_q), 16'(WAIT));
    chk("pre-reset wb_reg_wr", 16'(wb_reg_wr), 16'h1);
    chk("pre-reset status_q", 16'(status_q), 16'h5);
    #2;
    reset = 1'b1;
    #1;
    chk("mid-reset dmem_req", 16'(dmem_req), 16'h0);
    chk("mid-reset stall", 16'(stall), 16'h0);
    chk("mid-reset status_q", 16'(status_q), 16'h0);
    chk("mid-reset wb_reg_wr", 16'(wb_reg_wr), 16'h0);
    tick();
    reset = 1'b0;
    #1;
    chk("post-reset state", 16'(dut.u_fsm.state_q), 16'(IDLE));
    chk("post-reset stall", 16'(stall), 16'h0);
`ifdef MEM_STALL_CNT_EN
    chk("post-reset stall_cycles", stall_cycles, 16'd0);
`endif
    tick();

    // Load with three wait cycles, counted from a fresh reset.
    set_ex(1, 16'h0033, 16'h0000, 3'd3, 1, 1, 0, 3'b000, 0);
    tick();
    set_ex(0, 16'h0, 16'h0, 3'd0, 0, 0, 0, 3'b000, 0);
    wait_access(3, 16'h0F0F, 16'h0033, waits);
    chk("load3 stall cycles", 16'(waits), 16'd3);
    chk("load3 wb_data", wb_data, 16'h0F0F);
`ifdef MEM_STALL_CNT_EN
    chk("stall_cycles count", stall_cycles, 16'd3);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
